// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg: shared defaults, FSM state type and request legality check. Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_SIZE   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    // Exactly one of wr/rd, and the word must physically exist (no aliasing).
    function automatic logic is_legal_req(input logic        wr,
                                          input logic        rd,
                                          input logic [31:0] addr,
                                          input int unsigned mem_size);
        return (wr ^ rd) && (addr < mem_size);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// mem_array: MEM_SIZE x DATA_WIDTH storage, one write port, async read. Rev 1.0
// ============================================================================
`default_nettype none

module mem_array #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // The controller never reads out of range; the guard keeps the port defined anyway.
    assign rdata = (32'(raddr) < 32'(MEM_SIZE)) ? mem_q[raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/mem_slave_ctrl.sv
// ============================================================================
// mem_slave_ctrl: single-beat read/write memory slave with configurable read latency. Rev 1.0
// ============================================================================
`default_nettype none

module mem_slave_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  slv_rsp,
    output logic                  err
);

    localparam int CNT_W = 2;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_q, rsp_d;
    logic                  err_q, err_d;

    logic                  w_req;
    logic                  w_legal;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_req   = wr | rd;
    assign w_legal = is_legal_req(wr, rd, 32'(addr), MEM_SIZE);

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_mem_array (
        .clk   (clk),
        .reset (reset),
        .we    (w_mem_we),
        .waddr (addr),
        .wdata (wdata),
        .raddr (raddr_q),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rsp_d    = 1'b0;
        err_d    = 1'b0;
        w_mem_we = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    if (!w_legal) begin
                        rsp_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (wr) begin
                        w_mem_we = 1'b1;
                        rsp_d    = 1'b1;
                        state_d  = RESP;
                    end else begin
                        // Counter reaches zero on the edge before data is due.
                        raddr_d = addr;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = w_mem_rdata;
                    rsp_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata   = rdata_q;
    assign slv_rsp = rsp_q;
    assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_slave_ctrl.sv
// ============================================================================
// tb_mem_slave_ctrl: directed table, corner sequences and randomized model check. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_slave_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        wr_s    [3];
    logic        rd_s    [3];
    logic [3:0]  addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [31:0] rdata_s [3];
    logic        rsp_s   [3];
    logic        err_s   [3];

    int total = 0;
    int bad   = 0;

    // Instance 0: latency 1, 16 words; 1: latency 3, 16 words; 2: latency 4, 12 words.
    int size_m [3] = '{16, 16, 12};
    int lat_m  [3] = '{1, 3, 4};
    logic [31:0] mem_m [3][16];
    logic [31:0] rd_m  [3];

    mem_slave_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .wr(wr_s[0]), .rd(rd_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .slv_rsp(rsp_s[0]), .err(err_s[0]));

    mem_slave_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .wr(wr_s[1]), .rd(rd_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .slv_rsp(rsp_s[1]), .err(err_s[1]));

    mem_slave_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(12), .RD_LATENCY(4)) u_dut2 (
        .clk(clk), .reset(reset), .wr(wr_s[2]), .rd(rd_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .rdata(rdata_s[2]), .slv_rsp(rsp_s[2]), .err(err_s[2]));

    typedef struct {
        int          d;
        logic        w;
        logic        r;
        logic [3:0]  a;
        logic [31:0] wd;
        int          lat;
        logic        e;
        logic [31:0] rdv;
        string       nm;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one request, then count edges after the accept edge until slv_rsp.
    task automatic xact(input int d, input logic w, input logic r, input logic [3:0] a,
                        input logic [31:0] wd, output int lat, output logic e,
                        output logic [31:0] rdv);
        @(negedge clk);
        wr_s[d] = w; rd_s[d] = r; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge clk);
        #1;
        wr_s[d] = 1'b0; rd_s[d] = 1'b0; wdata_s[d] = $urandom;
        lat = 0;
        while (!rsp_s[d] && lat < 10) begin
            chk("err_without_rsp", 32'(err_s[d]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        e   = err_s[d];
        rdv = rdata_s[d];
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", 32'(rsp_s[d]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rdv;

        for (int i = 0; i < 3; i++) begin
            wr_s[i] = 1'b0; rd_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
        end

        // Reset then idle
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rdata", rdata_s[i], 32'd0);
            chk("rst_rsp", 32'(rsp_s[i]), 32'd0);
            chk("rst_err", 32'(err_s[i]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            xact(0, 1'b0, 1'b1, 4'(a), 32'd0, lat, e, rdv);
            chk("init_lat", lat, 32'd1);
            chk("init_err", 32'(e), 32'd0);
            chk("init_rdata", rdv, 32'd0);
        end

        // Directed vectors with hand-derived expectations
        tbl.push_back('{0, 1'b1, 1'b0, 4'd5,  32'hDEADBEEF, 0, 1'b0, 32'h0,        "t2_wr"});
        tbl.push_back('{0, 1'b0, 1'b1, 4'd5,  32'h0,        1, 1'b0, 32'hDEADBEEF, "t2_rd"});
        tbl.push_back('{1, 1'b1, 1'b0, 4'd15, 32'h000000A5, 0, 1'b0, 32'h0,        "t3_wr"});
        tbl.push_back('{0, 1'b1, 1'b1, 4'd2,  32'h11111111, 0, 1'b1, 32'hDEADBEEF, "t4_both"});
        tbl.push_back('{0, 1'b0, 1'b1, 4'd2,  32'h0,        1, 1'b0, 32'h0,        "t4_mem2"});
        tbl.push_back('{2, 1'b1, 1'b0, 4'd1,  32'h00001234, 0, 1'b0, 32'h0,        "t4_wr1"});
        tbl.push_back('{2, 1'b0, 1'b1, 4'd1,  32'h0,        4, 1'b0, 32'h00001234, "t4_rd1"});
        tbl.push_back('{2, 1'b0, 1'b1, 4'd13, 32'h0,        0, 1'b1, 32'h00001234, "t4_oor_rd"});
        tbl.push_back('{2, 1'b1, 1'b0, 4'd12, 32'hFFFFFFFF, 0, 1'b1, 32'h00001234, "t4_oor_wr"});
        tbl.push_back('{0, 1'b1, 1'b0, 4'd3,  32'h1,        0, 1'b0, 32'h0,        "t5_wr1"});
        foreach (tbl[i]) begin
            xact(tbl[i].d, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd, lat, e, rdv);
            chk({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
            chk({tbl[i].nm, "_err"}, 32'(e), 32'(tbl[i].e));
            chk({tbl[i].nm, "_rdata"}, rdv, tbl[i].rdv);
        end

        // Latency 3 read with rd held high during the wait cycles
        @(negedge clk);
        rd_s[1] = 1'b1; addr_s[1] = 4'd15;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("t3_rsp_timing", 32'(rsp_s[1]), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) chk("t3_rdata", rdata_s[1], 32'h000000A5);
            if (k == 2) rd_s[1] = 1'b0;
        end

        // Second write to addr 3, with a write held into the RESP cycle
        @(negedge clk);
        wr_s[0] = 1'b1; addr_s[0] = 4'd3; wdata_s[0] = 32'd2;
        @(posedge clk);
        #1;
        chk("t5_wr2_rsp", 32'(rsp_s[0]), 32'd1);
        chk("t5_wr2_err", 32'(err_s[0]), 32'd0);
        wdata_s[0] = 32'h99;
        @(posedge clk);
        #1;
        chk("t5_resp_wr_ignored", 32'(rsp_s[0]), 32'd0);
        wr_s[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_no_extra_rsp", 32'(rsp_s[0]), 32'd0);
        xact(0, 1'b0, 1'b1, 4'd3, 32'd0, lat, e, rdv);
        chk("t5_rd_lat", lat, 32'd1);
        chk("t5_rd_data", rdv, 32'd2);

        // Reset two cycles into a latency 4 read
        @(negedge clk);
        rd_s[2] = 1'b1; addr_s[2] = 4'd1;
        @(posedge clk);
        #1;
        rd_s[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rdata_cleared", rdata_s[2], 32'd0);
        chk("t6_rsp_low", 32'(rsp_s[2]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("t6_no_rsp", 32'(rsp_s[2]), 32'd0);
        end
        for (int a = 0; a < 12; a++) begin
            xact(2, 1'b0, 1'b1, 4'(a), 32'd0, lat, e, rdv);
            chk("t6_rd_lat", lat, 32'd4);
            chk("t6_rd_zero", rdv, 32'd0);
        end
        xact(0, 1'b0, 1'b1, 4'd5, 32'd0, lat, e, rdv);
        chk("t6_dut0_cleared", rdv, 32'd0);

        // Randomized traffic against the reference model (all state is zero after reset)
        for (int d = 0; d < 3; d++) begin
            rd_m[d] = (d == 0) ? 32'd0 : 32'd0;
            for (int a = 0; a < 16; a++) mem_m[d][a] = 32'd0;
        end
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                int          kind;
                logic        w, r, illegal;
                logic [3:0]  a;
                logic [31:0] wd;
                int          exp_lat;
                kind = $urandom_range(0, 9);
                a    = 4'($urandom_range(0, 15));
                wd   = $urandom;
                w    = (kind == 0) || (kind >= 2 && kind <= 5);
                r    = (kind == 0) || (kind >= 6);
                if (!w && !r) begin
                    @(negedge clk);
                    @(posedge clk);
                    #1;
                    chk("rnd_idle_no_rsp", 32'(rsp_s[d]), 32'd0);
                end else begin
                    illegal = (w && r) || (int'(a) >= size_m[d]);
                    exp_lat = 0;
                    if (!illegal && w) mem_m[d][a] = wd;
                    if (!illegal && r) begin
                        exp_lat = lat_m[d];
                        rd_m[d] = mem_m[d][a];
                    end
                    xact(d, w, r, a, wd, lat, e, rdv);
                    chk("rnd_lat", lat, exp_lat);
                    chk("rnd_err", 32'(e), 32'(illegal));
                    chk("rnd_rdata", rdv, rd_m[d]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_slave_ctrl.md
Name: mem_slave_ctrl

Overview:
Synchronous read/write memory slave, i.e. the DUT driven by the testbench memory interface. It accepts single-beat wr/rd requests from the bus master and stores data in an internal MEM_SIZE x DATA_WIDTH array. Each accepted request completes with a one-cycle slv_rsp pulse, after a configurable read latency for reads. It flags illegal requests on err.

Parameters:
ADDR_WIDTH, 4, address bus width in bits
DATA_WIDTH, 32, data word width in bits
MEM_SIZE, 16, number of implemented words; legal range 1..2**ADDR_WIDTH
RD_LATENCY, 1, cycles from read accept edge to rdata/slv_rsp edge; legal range 1..4

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
wr  input  1  write request; 1 = write
rd  input  1  read request; 1 = read
addr  input  ADDR_WIDTH  word address
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  read data
slv_rsp  output  1  one-cycle completion pulse for every accepted request
err  output  1  qualifies slv_rsp; 1 = request rejected

Behaviour:
- Reset (reset=0, async): state=IDLE, latency counter=0, rdata=0, slv_rsp=0, err=0, all array words=0. Takes effect immediately, including mid-read; an in-flight read is dropped with no slv_rsp.
- FSM states: IDLE, RD_WAIT, RESP.
- Requests are sampled only at a posedge in IDLE. wr/rd in RD_WAIT or RESP are ignored, not queued. The master must see slv_rsp before issuing its next request.
- Write accept at edge N (IDLE, wr=1, rd=0, addr<MEM_SIZE):
  - mem[addr]<=wdata at edge N.
  - slv_rsp=1, err=0 from edge N to N+1.
  - state->RESP, then IDLE at N+1. Max throughput is 1 request per 2 cycles.
- Read accept at edge N (IDLE, rd=1, wr=0, addr<MEM_SIZE):
  - addr is latched at edge N.
  - If RD_LATENCY=1: rdata<=mem[addr], slv_rsp=1 at edge N+1, state RESP.
  - Else: state->RD_WAIT, counter loaded with RD_LATENCY-1, decremented each cycle; at edge N+RD_LATENCY, rdata is loaded and slv_rsp=1.
  - RESP->IDLE on the next edge.
  - rdata holds its value until the next successful read or reset.
- Illegal request in IDLE: wr=1 and rd=1 together, or (wr|rd) with addr>=MEM_SIZE.
  - No array access; rdata unchanged.
  - slv_rsp=1 and err=1 for one cycle from the accept edge; state->RESP.
- wr=0 and rd=0 in IDLE: no action, outputs slv_rsp=0, err=0.
- err is only meaningful while slv_rsp=1; it is 0 otherwise.
- Read after write to the same address always returns the new data, because a write completes before the next accept.
- Address is used directly as the index with no wrap; an out-of-range address is an error, never aliased.
- wdata is don't-care except at a write accept edge.

Decomposition:
- Package mem_pkg:
  - default ADDR_WIDTH/DATA_WIDTH/MEM_SIZE localparams
  - state enum typedef (IDLE, RD_WAIT, RESP)
  - function is_legal_req(wr, rd, addr, MEM_SIZE)
- Sub-module mem_array:
  - storage only, parameterised on ADDR_WIDTH/DATA_WIDTH/MEM_SIZE
  - one write port (we, waddr, wdata)
  - one combinational read port
  - async active-low clear on reset
- mem_slave_ctrl holds the FSM, latency counter, and the rdata/slv_rsp/err registers.

Test Plan:
1. Reset then idle: reset=0 for 3 cycles, then 1. Required: rdata=0, slv_rsp=0, err=0; reading addr 0..15 returns 0 with err=0.
2. Write/read back (RD_LATENCY=1): write addr=5, wdata=32'hDEADBEEF -> slv_rsp pulse 1 cycle after accept; read addr=5 -> rdata=32'hDEADBEEF with slv_rsp on the edge after accept.
3. Latency sweep: RD_LATENCY=3, write addr=15, wdata=32'h0000_00A5, then read addr=15 -> slv_rsp exactly 3 edges after the read accept edge, rdata=32'h0000_00A5; rd pulses during RD_WAIT are ignored, producing no extra slv_rsp.
4. Illegal requests:
   - wr=1 and rd=1 together at addr=2 -> slv_rsp=1, err=1, and mem[2] unchanged on readback.
   - MEM_SIZE=12 with read addr=13 -> err=1, rdata holds its previous value.
5. Back-to-back writes: write addr=3 wdata=1 and addr=3 wdata=2, each issued after the prior slv_rsp -> readback of addr 3 = 2. A write presented during the RESP cycle is not accepted: no slv_rsp, and memory is unchanged.
6. Reset mid-read: RD_LATENCY=4, read accepted, reset asserted 2 cycles later -> rdata=0 immediately, no slv_rsp after release, state IDLE, and all words read back as 0.
